// File: rtl/buf_result_drain.sv
// buf_result_drain
// Scans the per-slot completion flags of the result buffers, captures each newly
// flagged (val_1, val_2) pair once and offers it on a valid/ready stream tagged
// with its slot index. Raises done once every slot has been drained.
//
// Optional feature macro: BUF_DRAIN_MIN_TRACK_EN
//   When defined, adds best_* outputs that track the emitted record with the
//   smallest val_1 (unsigned, strict less-than, first one kept on ties).
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   buf_val_1_s/_2_s    packed per-slot values, slot i at [i*DATA_W +: DATA_W]
//   buf_flag_s          per-slot "result valid" flags
//   out_valid/out_ready output stream handshake
//   out_idx, out_val_*  emitted record (registered)
//   done                all slots drained, sticky until Reset
//   best_*              minimum-val_1 record (BUF_DRAIN_MIN_TRACK_EN only)
module buf_result_drain #(
  parameter int unsigned N_ENTRIES = 61,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 6
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [N_ENTRIES*DATA_W-1:0]   buf_val_1_s,
  input  logic [N_ENTRIES*DATA_W-1:0]   buf_val_2_s,
  input  logic [N_ENTRIES-1:0]          buf_flag_s,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_idx,
  output logic [DATA_W-1:0]             out_val_1,
  output logic [DATA_W-1:0]             out_val_2,
  output logic                          done
`ifdef BUF_DRAIN_MIN_TRACK_EN
  ,
  output logic                          best_valid,
  output logic [IDX_W-1:0]              best_idx,
  output logic [DATA_W-1:0]             best_val_1,
  output logic [DATA_W-1:0]             best_val_2
`endif
);

  typedef enum logic [1:0] {StScan, StEmit, StDone} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic [N_ENTRIES-1:0]  sent_q, sent_d, hs_vec;
  logic                  out_valid_q, out_valid_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic [DATA_W-1:0]     out_val_1_q, out_val_1_d;
  logic [DATA_W-1:0]     out_val_2_q, out_val_2_d;
  logic                  hs;
  logic                  slot_pending;
  logic [DATA_W-1:0]     sel_val_1, sel_val_2;

  assign hs           = out_valid_q & out_ready;
  assign idx_inc      = (idx_q == IDX_W'(N_ENTRIES - 1)) ? '0 : idx_q + 1'b1;
  assign slot_pending = buf_flag_s[idx_q] & ~sent_q[idx_q];
  assign sel_val_1    = buf_val_1_s[32'(idx_q) * DATA_W +: DATA_W];
  assign sel_val_2    = buf_val_2_s[32'(idx_q) * DATA_W +: DATA_W];

  // One-hot handshake vector; idx_q still points at the emitted slot in EMIT.
  always_comb begin
    hs_vec = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      hs_vec[i] = hs && (idx_q == IDX_W'(i));
    end
  end

  // A dropped flag clears its sent bit (and wins over a same-cycle handshake),
  // so a slot that is later re-flagged gets emitted again.
  always_comb begin
    if (state_q == StDone) begin
      sent_d = sent_q;
    end else begin
      sent_d = buf_flag_s & (sent_q | hs_vec);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_val_1_d = out_val_1_q;
    out_val_2_d = out_val_2_q;
    unique case (state_q)
      StScan: begin
        if (slot_pending) begin
          out_valid_d = 1'b1;
          out_idx_d   = idx_q;
          out_val_1_d = sel_val_1;
          out_val_2_d = sel_val_2;
          state_d     = StEmit;
        end else begin
          idx_d = idx_inc;
        end
      end
      StEmit: begin
        // Captured record is held regardless of input changes until accepted.
        if (hs) begin
          out_valid_d = 1'b0;
          idx_d       = idx_inc;
          state_d     = (&sent_d) ? StDone : StScan;
        end
      end
      StDone: begin
        out_valid_d = 1'b0;
      end
      default: begin
        state_d     = StScan;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StScan;
      idx_q       <= '0;
      sent_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_val_1_q <= '0;
      out_val_2_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sent_q      <= sent_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_val_1_q <= out_val_1_d;
      out_val_2_q <= out_val_2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_val_1 = out_val_1_q;
  assign out_val_2 = out_val_2_q;
  assign done      = (state_q == StDone);

`ifdef BUF_DRAIN_MIN_TRACK_EN
  logic              best_valid_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [DATA_W-1:0] best_val_1_q, best_val_2_q;

  // Strict less-than keeps the earlier-emitted slot on ties.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_val_1_q <= '0;
      best_val_2_q <= '0;
    end else if (hs && (!best_valid_q || (out_val_1_q < best_val_1_q))) begin
      best_valid_q <= 1'b1;
      best_idx_q   <= out_idx_q;
      best_val_1_q <= out_val_1_q;
      best_val_2_q <= out_val_2_q;
    end
  end

  assign best_valid = best_valid_q;
  assign best_idx   = best_idx_q;
  assign best_val_1 = best_val_1_q;
  assign best_val_2 = best_val_2_q;
`endif

endmodule
